// File: rtl/pcie_us_fc_sampler_if.sv
// Flow-control pin bundle: cfg_fc_* credit inputs from the PCIe core, the sel mux drive,
// and the tagged snapshot stream towards the DMA side.
interface pcie_us_fc_sampler_if;
    logic [7:0]  cfg_fc_ph;
    logic [11:0] cfg_fc_pd;
    logic [7:0]  cfg_fc_nph;
    logic [11:0] cfg_fc_npd;
    logic [7:0]  cfg_fc_cplh;
    logic [11:0] cfg_fc_cpld;
    logic [2:0]  cfg_fc_sel;

    logic [2:0]  m_fc_sel;
    logic [7:0]  m_fc_ph;
    logic [11:0] m_fc_pd;
    logic [7:0]  m_fc_nph;
    logic [11:0] m_fc_npd;
    logic [7:0]  m_fc_cplh;
    logic [11:0] m_fc_cpld;
    logic        m_fc_valid;

    modport master (
        input  cfg_fc_ph, cfg_fc_pd, cfg_fc_nph, cfg_fc_npd, cfg_fc_cplh, cfg_fc_cpld,
        output cfg_fc_sel,
        output m_fc_sel, m_fc_ph, m_fc_pd, m_fc_nph, m_fc_npd, m_fc_cplh, m_fc_cpld, m_fc_valid
    );

    modport slave (
        output cfg_fc_ph, cfg_fc_pd, cfg_fc_nph, cfg_fc_npd, cfg_fc_cplh, cfg_fc_cpld,
        input  cfg_fc_sel,
        input  m_fc_sel, m_fc_ph, m_fc_pd, m_fc_nph, m_fc_npd, m_fc_cplh, m_fc_cpld, m_fc_valid
    );
endinterface

// File: rtl/pcie_us_fc_sampler.sv
// Time-shares the PCIe cfg_fc_sel mux over the enabled credit views and publishes tagged snapshots.
// Optional TX-available low watermarks are built when PCIE_FC_SAMPLER_WATERMARK_EN is defined.
module pcie_us_fc_sampler #(
    parameter logic [7:0] SEL_MASK     = 8'h70,
    parameter int         SEL_LATENCY  = 2,
    parameter int         PERIOD_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable_i,
    input  logic [PERIOD_WIDTH-1:0] period_i,
    pcie_us_fc_sampler_if.master    fc_if,
    output logic [7:0]              tx_fc_ph_av_o,
    output logic [11:0]             tx_fc_pd_av_o,
    output logic [7:0]              tx_fc_nph_av_o,
`ifdef PCIE_FC_SAMPLER_WATERMARK_EN
    input  logic                    wm_clear_i,
    output logic [7:0]              tx_fc_ph_min_o,
    output logic [11:0]             tx_fc_pd_min_o,
    output logic [7:0]              tx_fc_nph_min_o,
`endif
    output logic                    round_done_o,
    output logic                    busy_o
);
    localparam logic [7:0]              EM   = SEL_MASK & 8'h77;
    localparam logic [3:0]              LAT  = 4'(SEL_LATENCY);
    localparam logic [PERIOD_WIDTH-1:0] PONE = PERIOD_WIDTH'(1);
    localparam logic [2:0]              TX_AV_SEL = 3'b100;

    typedef enum logic [1:0] {IDLE, WAIT, CAPTURE, PAUSE} state_t;

    state_t                  state_q, state_d;
    logic [2:0]              sel_q, sel_d;
    logic [3:0]              wait_q, wait_d;
    logic [PERIOD_WIDTH-1:0] pause_q, pause_d;

    logic [2:0]  m_sel_q;
    logic [7:0]  m_ph_q;
    logic [11:0] m_pd_q;
    logic [7:0]  m_nph_q;
    logic [11:0] m_npd_q;
    logic [7:0]  m_cplh_q;
    logic [11:0] m_cpld_q;
    logic        m_valid_q;
    logic        done_q;
    logic [7:0]  tx_ph_q;
    logic [11:0] tx_pd_q;
    logic [7:0]  tx_nph_q;

    logic [7:0] above_mask;
    logic       first_found, next_found;
    logic [2:0] first_code, next_code;
    logic       capture_tx;

    // Enabled codes strictly above the one currently driven; lowest of them is the next select.
    for (genvar gi = 0; gi < 8; gi++) begin : g_above
        assign above_mask[gi] = EM[gi] && (sel_q < 3'(gi));
    end

    always_comb begin
        first_found = 1'b0;
        first_code  = 3'd0;
        next_found  = 1'b0;
        next_code   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (EM[i]) begin
                first_found = 1'b1;
                first_code  = 3'(i);
            end
            if (above_mask[i]) begin
                next_found = 1'b1;
                next_code  = 3'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        wait_d  = wait_q;
        pause_d = pause_q;
        case (state_q)
            IDLE: begin
                if (enable_i && first_found) begin
                    sel_d   = first_code;
                    wait_d  = LAT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // The counter never goes below one, so it cannot wrap.
                if (wait_q <= 4'd1) begin
                    state_d = CAPTURE;
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            CAPTURE: begin
                if (next_found) begin
                    sel_d   = next_code;
                    wait_d  = LAT;
                    state_d = WAIT;
                end else begin
                    pause_d = period_i;
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (pause_q == '0 || pause_q == PONE) begin
                    state_d = IDLE;
                end else begin
                    pause_d = pause_q - PONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign capture_tx = (state_q == CAPTURE) && (sel_q == TX_AV_SEL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= 3'd0;
            wait_q    <= 4'd0;
            pause_q   <= '0;
            m_sel_q   <= 3'd0;
            m_ph_q    <= 8'd0;
            m_pd_q    <= 12'd0;
            m_nph_q   <= 8'd0;
            m_npd_q   <= 12'd0;
            m_cplh_q  <= 8'd0;
            m_cpld_q  <= 12'd0;
            m_valid_q <= 1'b0;
            done_q    <= 1'b0;
            tx_ph_q   <= 8'd0;
            tx_pd_q   <= 12'd0;
            tx_nph_q  <= 8'd0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            wait_q    <= wait_d;
            pause_q   <= pause_d;
            m_valid_q <= 1'b0;
            done_q    <= 1'b0;
            if (state_q == CAPTURE) begin
                m_sel_q   <= sel_q;
                m_ph_q    <= fc_if.cfg_fc_ph;
                m_pd_q    <= fc_if.cfg_fc_pd;
                m_nph_q   <= fc_if.cfg_fc_nph;
                m_npd_q   <= fc_if.cfg_fc_npd;
                m_cplh_q  <= fc_if.cfg_fc_cplh;
                m_cpld_q  <= fc_if.cfg_fc_cpld;
                m_valid_q <= 1'b1;
                done_q    <= !next_found;
            end
            if (capture_tx) begin
                tx_ph_q  <= fc_if.cfg_fc_ph;
                tx_pd_q  <= fc_if.cfg_fc_pd;
                tx_nph_q <= fc_if.cfg_fc_nph;
            end
        end
    end

`ifdef PCIE_FC_SAMPLER_WATERMARK_EN
    logic [7:0]  ph_min_q, ph_base;
    logic [11:0] pd_min_q, pd_base;
    logic [7:0]  nph_min_q, nph_base;

    // A clear in the capture cycle restarts from all-ones, so the captured value wins.
    always_comb begin
        ph_base  = wm_clear_i ? '1 : ph_min_q;
        pd_base  = wm_clear_i ? '1 : pd_min_q;
        nph_base = wm_clear_i ? '1 : nph_min_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ph_min_q  <= '1;
            pd_min_q  <= '1;
            nph_min_q <= '1;
        end else if (capture_tx) begin
            ph_min_q  <= (fc_if.cfg_fc_ph  < ph_base)  ? fc_if.cfg_fc_ph  : ph_base;
            pd_min_q  <= (fc_if.cfg_fc_pd  < pd_base)  ? fc_if.cfg_fc_pd  : pd_base;
            nph_min_q <= (fc_if.cfg_fc_nph < nph_base) ? fc_if.cfg_fc_nph : nph_base;
        end else if (wm_clear_i) begin
            ph_min_q  <= '1;
            pd_min_q  <= '1;
            nph_min_q <= '1;
        end
    end

    assign tx_fc_ph_min_o  = ph_min_q;
    assign tx_fc_pd_min_o  = pd_min_q;
    assign tx_fc_nph_min_o = nph_min_q;
`endif

    assign fc_if.cfg_fc_sel = sel_q;
    assign fc_if.m_fc_sel   = m_sel_q;
    assign fc_if.m_fc_ph    = m_ph_q;
    assign fc_if.m_fc_pd    = m_pd_q;
    assign fc_if.m_fc_nph   = m_nph_q;
    assign fc_if.m_fc_npd   = m_npd_q;
    assign fc_if.m_fc_cplh  = m_cplh_q;
    assign fc_if.m_fc_cpld  = m_cpld_q;
    assign fc_if.m_fc_valid = m_valid_q;
    assign tx_fc_ph_av_o    = tx_ph_q;
    assign tx_fc_pd_av_o    = tx_pd_q;
    assign tx_fc_nph_av_o   = tx_nph_q;
    assign round_done_o     = done_q;
    assign busy_o           = (state_q != IDLE);
endmodule

// File: tb/tb_pcie_us_fc_sampler.sv
// Directed bench for pcie_us_fc_sampler: a lagged core model feeds cfg_fc_*, a scoreboard
// queue holds the expected snapshots and their arrival cycles.
module tb_pcie_us_fc_sampler;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] period = 16'd0;
    logic [7:0]  tx_ph_av, tx_nph_av, tx_ph_av2, tx_nph_av2;
    logic [11:0] tx_pd_av, tx_pd_av2;
    logic        round_done, busy, round_done2, busy2;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    logic [7:0]  ph_tab   [8];
    logic [11:0] pd_tab   [8];
    logic [7:0]  nph_tab  [8];
    logic [11:0] npd_tab  [8];
    logic [7:0]  cplh_tab [8];
    logic [11:0] cpld_tab [8];
    logic [2:0]  lag1 = 3'd0, lag2 = 3'd0;

    typedef struct {
        int          cyc;
        logic [2:0]  sel;
        logic [7:0]  ph;
        logic [11:0] pd;
        logic [7:0]  nph;
        logic [11:0] npd;
        logic [7:0]  cplh;
        logic [11:0] cpld;
        logic        done;
    } exp_t;
    exp_t sb[$];

    pcie_us_fc_sampler_if fc_if ();
    pcie_us_fc_sampler_if fc2_if ();

`ifdef PCIE_FC_SAMPLER_WATERMARK_EN
    logic        wm_clear = 1'b0;
    logic [7:0]  ph_min, nph_min, ph_min2, nph_min2;
    logic [11:0] pd_min, pd_min2;
`endif

    pcie_us_fc_sampler #(.SEL_MASK(8'h70), .SEL_LATENCY(LAT), .PERIOD_WIDTH(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .enable_i       (enable),
        .period_i       (period),
        .fc_if          (fc_if),
        .tx_fc_ph_av_o  (tx_ph_av),
        .tx_fc_pd_av_o  (tx_pd_av),
        .tx_fc_nph_av_o (tx_nph_av),
`ifdef PCIE_FC_SAMPLER_WATERMARK_EN
        .wm_clear_i     (wm_clear),
        .tx_fc_ph_min_o (ph_min),
        .tx_fc_pd_min_o (pd_min),
        .tx_fc_nph_min_o(nph_min),
`endif
        .round_done_o   (round_done),
        .busy_o         (busy)
    );

    // Only reserved codes enabled: this instance must never leave IDLE.
    pcie_us_fc_sampler #(.SEL_MASK(8'h88), .SEL_LATENCY(LAT), .PERIOD_WIDTH(16)) dut_rsv (
        .clk            (clk),
        .rst            (rst),
        .enable_i       (enable),
        .period_i       (period),
        .fc_if          (fc2_if),
        .tx_fc_ph_av_o  (tx_ph_av2),
        .tx_fc_pd_av_o  (tx_pd_av2),
        .tx_fc_nph_av_o (tx_nph_av2),
`ifdef PCIE_FC_SAMPLER_WATERMARK_EN
        .wm_clear_i     (wm_clear),
        .tx_fc_ph_min_o (ph_min2),
        .tx_fc_pd_min_o (pd_min2),
        .tx_fc_nph_min_o(nph_min2),
`endif
        .round_done_o   (round_done2),
        .busy_o         (busy2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Core model: credit values follow cfg_fc_sel two cycles late.
    always @(posedge clk) begin
        lag1 <= fc_if.cfg_fc_sel;
        lag2 <= lag1;
    end
    assign fc_if.cfg_fc_ph   = ph_tab[lag2];
    assign fc_if.cfg_fc_pd   = pd_tab[lag2];
    assign fc_if.cfg_fc_nph  = nph_tab[lag2];
    assign fc_if.cfg_fc_npd  = npd_tab[lag2];
    assign fc_if.cfg_fc_cplh = cplh_tab[lag2];
    assign fc_if.cfg_fc_cpld = cpld_tab[lag2];

    assign fc2_if.cfg_fc_ph   = 8'h20;
    assign fc2_if.cfg_fc_pd   = 12'h020;
    assign fc2_if.cfg_fc_nph  = 8'h20;
    assign fc2_if.cfg_fc_npd  = 12'h020;
    assign fc2_if.cfg_fc_cplh = 8'h20;
    assign fc2_if.cfg_fc_cpld = 12'h020;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // One round over sel 4,5,6: first snapshot at 'first', then every LAT+1 cycles.
    task automatic push_round(input int first);
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            e.cyc  = first + k * (LAT + 1);
            e.sel  = 3'(4 + k);
            e.ph   = ph_tab[4 + k];
            e.pd   = pd_tab[4 + k];
            e.nph  = nph_tab[4 + k];
            e.npd  = npd_tab[4 + k];
            e.cplh = cplh_tab[4 + k];
            e.cpld = cpld_tab[4 + k];
            e.done = (k == 2);
            sb.push_back(e);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
            check("missed_valid_cycle", cyc, sb[0].cyc);
            void'(sb.pop_front());
        end
        if (fc_if.m_fc_valid === 1'b1) begin
            check("valid_expected", (sb.size() > 0), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                $display("snapshot cyc=%0d sel=%0d ph=%0h pd=%0h nph=%0h npd=%0h cplh=%0h cpld=%0h done=%0b",
                         cyc, fc_if.m_fc_sel, fc_if.m_fc_ph, fc_if.m_fc_pd, fc_if.m_fc_nph,
                         fc_if.m_fc_npd, fc_if.m_fc_cplh, fc_if.m_fc_cpld, round_done);
                check("valid_cycle", cyc, e.cyc);
                check("m_fc_sel", fc_if.m_fc_sel, e.sel);
                check("m_fc_ph", fc_if.m_fc_ph, e.ph);
                check("ph_is_sel_x16", fc_if.m_fc_ph, {1'b0, fc_if.m_fc_sel, 4'h0});
                check("m_fc_pd", fc_if.m_fc_pd, e.pd);
                check("m_fc_nph", fc_if.m_fc_nph, e.nph);
                check("m_fc_npd", fc_if.m_fc_npd, e.npd);
                check("m_fc_cplh", fc_if.m_fc_cplh, e.cplh);
                check("m_fc_cpld", fc_if.m_fc_cpld, e.cpld);
                check("round_done", round_done, e.done);
            end
        end else if (round_done === 1'b1) begin
            check("round_done_without_valid", fc_if.m_fc_valid, 1);
        end
        if (!rst) begin
            check("rsv_busy", busy2, 0);
            check("rsv_valid", fc2_if.m_fc_valid, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int r;
        for (int s = 0; s < 8; s++) begin
            ph_tab[s]   = 8'(s * 16);
            pd_tab[s]   = 12'(12'h100 + s);
            nph_tab[s]  = 8'(8'h30 + s);
            npd_tab[s]  = 12'(12'h200 + s);
            cplh_tab[s] = 8'(8'h50 + s);
            cpld_tab[s] = 12'(12'h300 + s);
        end

        // Reset values
        goto(3);
        check("rst_cfg_fc_sel", fc_if.cfg_fc_sel, 0);
        check("rst_m_fc_valid", fc_if.m_fc_valid, 0);
        check("rst_m_fc_ph", fc_if.m_fc_ph, 0);
        check("rst_m_fc_cpld", fc_if.m_fc_cpld, 0);
        check("rst_tx_ph_av", tx_ph_av, 0);
        check("rst_round_done", round_done, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        goto(6);

        // Back-to-back rounds, enable dropped during the second round's sel-5 WAIT
        e = cyc;
        period = 16'd0;
        enable = 1'b1;
        push_round(e + LAT + 2);
        push_round(e + 3 * (LAT + 1) + 1 + LAT + 2 + 1 - 1 + 1);
        goto(e + 1);
        check("first_cfg_fc_sel", fc_if.cfg_fc_sel, 4);
        check("busy_in_wait", busy, 1);
        goto(e + 16);
        enable = 1'b0;
        goto(e + 45);
        check("parked_busy", busy, 0);
        check("sb_drained_a", sb.size(), 0);
        check("tx_ph_av", tx_ph_av, 8'h40);
        check("tx_pd_av", tx_pd_av, pd_tab[4]);
        check("tx_nph_av", tx_nph_av, nph_tab[4]);

        // period=10 between rounds
        e = cyc;
        period = 16'd10;
        enable = 1'b1;
        push_round(e + LAT + 2);
        r = e + LAT + 2 + 2 * (LAT + 1);
        push_round(r + 10 + LAT + 2);
        goto(r + 9);
        check("pause_busy", busy, 1);
        goto(r + 10);
        check("idle_rearm_busy", busy, 0);
        check("idle_sel_held", fc_if.cfg_fc_sel, 6);
        goto(r + 11);
        check("rearm_cfg_fc_sel", fc_if.cfg_fc_sel, 4);
        enable = 1'b0;
        goto(r + 45);
        check("sb_drained_b", sb.size(), 0);
        check("parked_busy_b", busy, 0);
        period = 16'd0;

        // Reset during WAIT
        e = cyc;
        enable = 1'b1;
        goto(e + 2);
        check("wait_busy_before_rst", busy, 1);
        rst = 1'b1;
        goto(e + 3);
        check("midrst_cfg_fc_sel", fc_if.cfg_fc_sel, 0);
        check("midrst_busy", busy, 0);
        check("midrst_m_fc_ph", fc_if.m_fc_ph, 0);
        check("midrst_m_fc_sel", fc_if.m_fc_sel, 0);
        check("midrst_tx_ph_av", tx_ph_av, 0);
        check("midrst_round_done", round_done, 0);
        enable = 1'b0;
        rst = 1'b0;
        goto(e + 20);
        check("no_partial_snapshot", fc_if.m_fc_valid, 0);

`ifdef PCIE_FC_SAMPLER_WATERMARK_EN
        check("wm_reset_pd_min", pd_min, 12'hfff);
        for (int k = 0; k < 4; k++) begin
            pd_tab[4] = (k == 0) ? 12'd100 : (k == 1) ? 12'd40 : (k == 2) ? 12'd80 : 12'd90;
            e = cyc;
            enable = 1'b1;
            push_round(e + LAT + 2);
            goto(e + 1);
            enable = 1'b0;
            if (k == 3) begin
                goto(e + LAT + 1);
                wm_clear = 1'b1;
                goto(e + LAT + 2);
                wm_clear = 1'b0;
            end
            goto(e + 16);
            if (k == 2) begin
                check("wm_pd_min_40", pd_min, 12'd40);
                check("wm_ph_min", ph_min, 8'h40);
                check("wm_nph_min", nph_min, nph_tab[4]);
            end
        end
        check("wm_clear_capture_wins", pd_min, 12'd90);
        check("sb_drained_wm", sb.size(), 0);
`endif

        check("rsv_cfg_fc_sel", fc2_if.cfg_fc_sel, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
